raycast_wb_arbiter: RTL and testbench
=====================================

RAYCAST_WB_ARBITER -- requirements
Module: raycast_wb_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- n_ports, 4, number of requesting raycast cores; fixed 4 in this revision.
- timeout_cycles, 255, maximum cycles in S_BUSY before abort; 8-bit.
REQ-002 Ports (name  direction  width  meaning):
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- s_wb_adr_i  input  128  requester addresses; port k at bits [32k+31:32k].
- s_wb_cyc_i  input  4  requester cycle; bit k = port k.
- s_wb_stb_i  input  4  requester strobe.
- s_wb_ack_o  output  4  requester acknowledge.
- s_wb_dat_o  output  32  read data, broadcast to all ports.
- m_wb_adr_o  output  32  shared-bus address.
- m_wb_dat_i  input  32  shared-bus read data.
- m_wb_cyc_o  output  1  shared-bus cycle.
- m_wb_stb_o  output  1  shared-bus strobe.
- m_wb_ack_i  input  1  shared-bus acknowledge.
- grant_o  output  4  one-hot current grant; zero when idle.
- timeout_o  output  1  sticky abort flag.
- timeout_clr_i  input  1  clears timeout_o.

Function
REQ-003 States: S_IDLE, S_BUSY, S_ABORT; 2-bit encoding.
REQ-004 Request of port k = s_wb_cyc_i[k] & s_wb_stb_i[k].
REQ-005 S_IDLE, any request: grant goes to the first requesting port scanning from rr_ptr upward, mod 4. grant registered; next state S_BUSY.
REQ-006 S_IDLE, no request: stay; grant_o = 0; m_wb_cyc_o = 0.
REQ-007 S_BUSY, bus drive: m_wb_cyc_o/m_wb_stb_o = s_wb_cyc_i[g] & s_wb_stb_i[g], and m_wb_adr_o = adr of port g, combinationally; g = granted index.
REQ-008 S_BUSY, return path: s_wb_ack_o[g] = m_wb_ack_i and s_wb_dat_o = m_wb_dat_i, combinationally. All other ack bits are 0.
REQ-009 S_BUSY, m_wb_ack_i = 1: next state S_IDLE; rr_ptr <= (g+1) mod 4.
REQ-010 S_BUSY, s_wb_cyc_i[g] = 0 without ack: next state S_IDLE; rr_ptr <= (g+1) mod 4; no ack issued.
REQ-011 Watchdog counter: 8 bits, cleared on entry to S_BUSY, +1 per S_BUSY cycle without ack.
REQ-012 Watchdog expiry: when the counter equals timeout_cycles-1 and m_wb_ack_i = 0, next state S_ABORT.
REQ-013 S_ABORT (one cycle): m_wb_cyc_o = 0; s_wb_ack_o[g] = 1; s_wb_dat_o = 32'h0; timeout_o <= 1; rr_ptr <= (g+1) mod 4; next state S_IDLE.
REQ-014 m_wb_ack_i outside S_BUSY is ignored; it produces no s_wb_ack_o.
REQ-015 Latency: transaction start is registered. Master cycle begins 1 clk after the request is seen in S_IDLE. There is 1 dead cycle between back-to-back grants.
REQ-016 Fairness: with all 4 ports requesting continuously, grants are issued in order 0,1,2,3,0,...
REQ-017 timeout_o: timeout_clr_i clears it, and set wins when set and clear coincide.
REQ-018 s_wb_dat_o = 0 in S_IDLE.

Reset
REQ-019 rst low, asynchronously: state = S_IDLE, rr_ptr = 0, grant = 0, watchdog = 0, timeout_o = 0.
REQ-020 While rst is low, all ack outputs, m_wb_cyc_o and m_wb_stb_o are 0.
REQ-021 Reset mid-transaction drops m_wb_cyc_o immediately; any late slave ack is ignored per REQ-014.

Structure
REQ-022 State encodings and the port-count constant live in the shared raycast_defines include.
REQ-023 Round-robin priority selection (rr_ptr, request vector -> one-hot winner) is one combinational sub-module, raycast_rr_select.

Verification
REQ-024 Single request: port 2, adr 32'h100, slave acks on the 3rd cycle with 32'hDEADBEEF -> s_wb_ack_o = 4'b0100 for 1 cycle, s_wb_dat_o = 32'hDEADBEEF; rr_ptr becomes 3.
REQ-025 All 4 ports request continuously, slave acks after 1 cycle -> grant order 0,1,2,3,0, with 1 idle cycle between grants.
REQ-026 Slave never acks, timeout_cycles = 8 -> S_ABORT after 8 S_BUSY cycles; granted port gets ack with data 0; timeout_o = 1; timeout_clr_i pulse -> timeout_o = 0.
REQ-027 Port 1 drops cyc in S_BUSY without ack -> return to S_IDLE with no ack; next grant favours port 2.
REQ-028 Reset low during S_BUSY, slave acks 2 cycles later -> no s_wb_ack_o asserted; state S_IDLE.
REQ-029 Simultaneous timeout set and timeout_clr_i -> timeout_o = 1.

Source files
------------

// File: rtl/raycast_wb_arbiter_pkg.sv
// Shared definitions for the raycast Wishbone arbiter.
// FSM states, port count and a one-hot index helper.
package raycast_wb_arbiter_pkg;

  localparam int N_PORTS = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/raycast_wb_arbiter_rr_select.sv
// Round-robin winner pick: first requester at or after ptr.
// Purely combinational; returns a one-hot winner or zero.
module raycast_rr_select
  import raycast_wb_arbiter_pkg::*;
#(
  parameter int n = N_PORTS
) (
  input  logic [1:0] ptr,
  input  logic [3:0] req,
  output logic [3:0] win
);

  logic       found;
  logic [1:0] idx;

  // scan upward from ptr, wrapping, keep the first hit
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < n; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/raycast_wb_arbiter.sv
// Four-port Wishbone arbiter for raycast cores.
// Round-robin grant, watchdog abort, sticky timeout flag.
module raycast_wb_arbiter
  import raycast_wb_arbiter_pkg::*;
#(
  parameter int n_ports        = N_PORTS,
  parameter int timeout_cycles = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_wb_adr_i,
  input  logic [3:0]   s_wb_cyc_i,
  input  logic [3:0]   s_wb_stb_i,
  output logic [3:0]   s_wb_ack_o,
  output logic [31:0]  s_wb_dat_o,
  output logic [31:0]  m_wb_adr_o,
  input  logic [31:0]  m_wb_dat_i,
  output logic         m_wb_cyc_o,
  output logic         m_wb_stb_o,
  input  logic         m_wb_ack_i,
  output logic [3:0]   grant_o,
  output logic         timeout_o,
  input  logic         timeout_clr_i
);

  localparam logic [7:0] WD_LAST = 8'(timeout_cycles - 1);

  state_t     state, state_nxt;
  logic [1:0] rr_ptr, rr_ptr_nxt;
  logic [3:0] grant, grant_nxt;
  logic [7:0] wdog, wdog_nxt;
  logic       timeout_q;
  logic [3:0] req, win;
  logic [1:0] g;
  logic       g_req;

  assign req   = s_wb_cyc_i & s_wb_stb_i;
  assign g     = oh_to_idx(grant);
  assign g_req = req[g];

  raycast_rr_select #(
    .n (n_ports)
  ) u_sel (
    .ptr (rr_ptr),
    .req (req),
    .win (win)
  );

  // state, pointer, grant and watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      rr_ptr <= 2'd0;
      grant  <= 4'd0;
      wdog   <= 8'd0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
      wdog   <= wdog_nxt;
    end
  end

  // sticky abort flag; a new abort beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if (state == S_ABORT) begin
      timeout_q <= 1'b1;
    end else if (timeout_clr_i) begin
      timeout_q <= 1'b0;
    end
  end

  // next-state: arbitrate, finish, drop-out or watchdog abort
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    wdog_nxt   = wdog;
    unique case (state)
      S_IDLE: begin
        if (|req) begin
          state_nxt = S_BUSY;
          grant_nxt = win;
          wdog_nxt  = 8'd0;
        end
      end
      S_BUSY: begin
        if (m_wb_ack_i || !s_wb_cyc_i[g]) begin
          state_nxt  = S_IDLE;
          rr_ptr_nxt = g + 2'd1;
          grant_nxt  = 4'd0;
        end else if (wdog == WD_LAST) begin
          state_nxt = S_ABORT;
        end else begin
          wdog_nxt = wdog + 8'd1;
        end
      end
      S_ABORT: begin
        state_nxt  = S_IDLE;
        rr_ptr_nxt = g + 2'd1;
        grant_nxt  = 4'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 4'd0;
      end
    endcase
  end

  // bus and return-path muxing for the granted port
  always_comb begin
    m_wb_cyc_o = 1'b0;
    m_wb_stb_o = 1'b0;
    m_wb_adr_o = 32'd0;
    s_wb_ack_o = 4'd0;
    s_wb_dat_o = 32'd0;
    unique case (state)
      S_BUSY: begin
        m_wb_cyc_o    = g_req;
        m_wb_stb_o    = g_req;
        m_wb_adr_o    = s_wb_adr_i[{g, 5'd0} +: 32];
        s_wb_ack_o[g] = m_wb_ack_i;
        s_wb_dat_o    = m_wb_dat_i;
      end
      S_ABORT: begin
        s_wb_ack_o[g] = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_o   = grant;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_raycast_wb_arbiter.sv
// Bench for raycast_wb_arbiter: directed scenarios then random
// traffic, all checked against a cycle-level reference model.
module tb_raycast_wb_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_adr;
  logic [3:0]   s_cyc, s_stb, s_ack;
  logic [31:0]  s_dat, m_adr, m_dat;
  logic         m_cyc, m_stb, m_ack;
  logic [3:0]   grant;
  logic         tout, clr;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // reference model: phase 0 idle, 1 bus owned, 2 abort
  int mph, mptr, mg, mwd;
  bit mto;

  raycast_wb_arbiter #(
    .timeout_cycles (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_wb_adr_i    (s_adr),
    .s_wb_cyc_i    (s_cyc),
    .s_wb_stb_i    (s_stb),
    .s_wb_ack_o    (s_ack),
    .s_wb_dat_o    (s_dat),
    .m_wb_adr_o    (m_adr),
    .m_wb_dat_i    (m_dat),
    .m_wb_cyc_o    (m_cyc),
    .m_wb_stb_o    (m_stb),
    .m_wb_ack_i    (m_ack),
    .grant_o       (grant),
    .timeout_o     (tout),
    .timeout_clr_i (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mph = 0; mptr = 0; mg = 0; mwd = 0; mto = 0;
  endtask

  // compare every output against the model, inputs settled
  task automatic settle();
    logic [3:0]  eg, ea;
    logic        ec;
    logic [31:0] ed;
    #1;
    if (!rst) model_reset();
    eg = '0; ea = '0; ec = 1'b0; ed = '0;
    if (mph == 1) begin
      eg = 4'(1 << mg);
      ec = s_cyc[mg] & s_stb[mg];
      ed = m_dat;
      if (m_ack) ea = eg;
    end else if (mph == 2) begin
      eg = 4'(1 << mg);
      ea = eg;
    end
    check("grant", 32'(grant), 32'(eg));
    check("s_ack", 32'(s_ack), 32'(ea));
    check("m_cyc", 32'(m_cyc), 32'(ec));
    check("m_stb", 32'(m_stb), 32'(ec));
    check("s_dat", s_dat, ed);
    check("timeout", 32'(tout), 32'(mto));
    if (mph == 1) check("m_adr", m_adr, s_adr[mg*32 +: 32]);
  endtask

  // advance model and DUT one clock
  task automatic adv();
    int nph, nptr, ng, nwd;
    bit nto;
    nph = mph; nptr = mptr; ng = mg; nwd = mwd; nto = mto;
    if (!rst) begin
      nph = 0; nptr = 0; ng = 0; nwd = 0; nto = 0;
    end else begin
      if (mph == 0) begin
        for (int i = 0; i < 4; i++) begin
          int k;
          k = (mptr + i) % 4;
          if (s_cyc[k] && s_stb[k]) begin
            nph = 1; ng = k; nwd = 0;
            break;
          end
        end
      end else if (mph == 1) begin
        if (m_ack || !s_cyc[mg]) begin
          nph = 0; nptr = (mg + 1) % 4;
        end else if (mwd == TO - 1) begin
          nph = 2;
        end else begin
          nwd = mwd + 1;
        end
      end else begin
        nph = 0; nptr = (mg + 1) % 4;
      end
      if (mph == 2) nto = 1;
      else if (clr) nto = 0;
    end
    @(posedge clk);
    mph = nph; mptr = nptr; mg = ng; mwd = nwd; mto = nto;
    @(negedge clk);
  endtask

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  initial begin
    int seq[$];
    int exp_order[5];
    exp_order = '{3, 0, 1, 2, 3};
    rst = 1'b0; s_adr = '0; s_cyc = '0; s_stb = '0;
    m_dat = '0; m_ack = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);

    // reset state
    settle(); adv(); settle(); adv();
    rst = 1'b1;

    // single request on port 2, slave acks on third bus cycle
    s_cyc = 4'b0100; s_stb = 4'b0100;
    s_adr[95:64] = 32'h100; m_dat = 32'hDEADBEEF;
    for (int t = 0; t < 5; t++) begin
      m_ack = (t == 3);
      if (t == 4) begin s_cyc = '0; s_stb = '0; end
      settle();
      if (t == 1) check("adr_p2", m_adr, 32'h100);
      if (t == 3) begin
        check("ack_p2", 32'(s_ack), 32'h4);
        check("dat_p2", s_dat, 32'hDEADBEEF);
      end
      adv();
    end
    m_ack = 1'b0;

    // all ports request, instant ack: rotation from port 3
    s_adr = {32'hC, 32'h8, 32'h4, 32'h0};
    s_cyc = 4'hF; s_stb = 4'hF; m_ack = 1'b1;
    for (int t = 0; t < 10; t++) begin
      settle();
      if (grant != 0) seq.push_back(idx_of(grant));
      adv();
    end
    check("fair_len", 32'(seq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("fair_order", 32'(seq[i]), 32'(exp_order[i]));
    s_cyc = '0; s_stb = '0; m_ack = 1'b0;
    settle(); adv();

    // watchdog abort; second pass clears during the abort cycle
    for (int rep = 0; rep < 2; rep++) begin
      s_cyc = 4'b0001; s_stb = 4'b0001; m_dat = 32'h5555_AAAA;
      for (int t = 0; t < 14; t++) begin
        if (t == 9) begin s_cyc = '0; s_stb = '0; end
        clr = (rep == 0) ? (t == 11) : (t == 9 || t == 11);
        settle();
        if (t == 8) check("busy_before_abort", 32'(m_cyc), 32'd1);
        if (t == 9) begin
          check("abort_ack", 32'(s_ack), 32'h1);
          check("abort_dat", s_dat, 32'h0);
          check("abort_cyc", 32'(m_cyc), 32'd0);
        end
        if (t == 10) check("timeout_set", 32'(tout), 32'd1);
        if (t == 12) check("timeout_clr", 32'(tout), 32'd0);
        adv();
      end
      clr = 1'b0;
    end

    // port 1 drops cyc mid-transfer; port 2 wins next
    s_cyc = 4'b0010; s_stb = 4'b0010;
    for (int t = 0; t < 6; t++) begin
      if (t == 2) s_cyc = '0;
      if (t == 3) begin s_cyc = 4'hF; s_stb = 4'hF; end
      m_ack = (t == 4);
      if (t == 5) begin s_cyc = '0; s_stb = '0; end
      settle();
      if (t == 2) check("drop_noack", 32'(s_ack), 32'h0);
      if (t == 4) check("drop_next", 32'(grant), 32'h4);
      adv();
    end
    m_ack = 1'b0;

    // asynchronous reset mid-transfer, late slave ack ignored
    s_cyc = 4'b0001; s_stb = 4'b0001;
    settle(); adv();
    settle(); adv();
    rst = 1'b0;
    settle();
    check("rst_cyc", 32'(m_cyc), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    adv();
    rst = 1'b1; s_cyc = '0; s_stb = '0; m_ack = 1'b1;
    for (int t = 0; t < 2; t++) begin
      settle();
      check("late_ack", 32'(s_ack), 32'd0);
      adv();
    end
    m_ack = 1'b0;

    // random traffic
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(7) == 0) s_cyc[k] = ~s_cyc[k];
        s_stb[k] = s_cyc[k] & ($urandom_range(5) != 0);
      end
      s_adr = {$urandom, $urandom, $urandom, $urandom};
      m_dat = $urandom;
      m_ack = ($urandom_range(5) == 0);
      clr   = ($urandom_range(15) == 0);
      settle();
      adv();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
